// File: rtl/tm_clause_engine.sv
// Chunk-serial Tsetlin Machine clause evaluator for one class: streams exclude masks
// per chunk, ANDs literal matches, emits clause vector and signed class sum.
// Optional: define TM_EMPTY_CLAUSE_ZERO_EN to force clauses with no included literal to 0.
module tm_clause_engine #(
    parameter int  N_FEATURES = 784,
    parameter int  CHUNK      = 32,
    parameter int  N_CLAUSES  = 16,
    localparam int NCHUNK     = (N_FEATURES + CHUNK - 1) / CHUNK,
    localparam int AW         = ($clog2(NCHUNK) > 1) ? $clog2(NCHUNK) : 1,
    localparam int SUM_W      = $clog2(N_CLAUSES) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_FEATURES-1:0]         features,
    output logic                          ta_rd_en,
    output logic [AW-1:0]                 ta_addr,
    input  logic [N_CLAUSES*2*CHUNK-1:0]  ta_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_CLAUSES-1:0]          clause_out,
    output logic signed [SUM_W-1:0]       class_sum
);

    localparam int PADDED = NCHUNK * CHUNK;
    localparam int CW     = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           rd_cnt;
    logic [PADDED-1:0]       feat_q;
    logic [N_CLAUSES-1:0]    acc;
    logic [N_CLAUSES-1:0]    chunk_pass;
    logic [N_CLAUSES-1:0]    clause_eff;
    logic [AW-1:0]           ev_idx;
    logic [CHUNK-1:0]        f_chunk;
    logic [CHUNK-1:0]        pad;
    logic                    accept;
    logic                    ev_en;
    logic                    last_ev;
    logic signed [SUM_W-1:0] sum_acc;

    assign accept  = in_valid & in_ready;
    // rd_cnt counts reads issued; the chunk read one cycle earlier is evaluated now.
    assign ev_en   = (state == RUN) && (rd_cnt != '0);
    assign last_ev = (state == RUN) && (rd_cnt == CW'(NCHUNK));
    assign ev_idx  = ev_en ? AW'(rd_cnt - CW'(1)) : '0;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ta_rd_en  = 1'b0;
        ta_addr   = '0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (rd_cnt < CW'(NCHUNK)) begin
                    ta_rd_en = 1'b1;
                    ta_addr  = rd_cnt[AW-1:0];
                end
                if (last_ev) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-chunk literal evaluation; padding lanes pass whatever the mask says.
    always_comb begin
        logic [2*CHUNK-1:0] lane;
        lane       = '0;
        chunk_pass = '0;
        f_chunk    = feat_q[int'(ev_idx)*CHUNK +: CHUNK];
        for (int j = 0; j < CHUNK; j++)
            pad[j] = (int'(ev_idx) * CHUNK + j) >= N_FEATURES;
        for (int c = 0; c < N_CLAUSES; c++) begin
            lane          = ta_rdata[c*2*CHUNK +: 2*CHUNK];
            chunk_pass[c] = &(lane | {f_chunk | pad, ~f_chunk | pad});
        end
    end

    // NOTE: the wide feature register carries no reset; it is always loaded on
    // accept before it is read, so a reset would only cost routing.
    always_ff @(posedge clk) begin
        if (accept) feat_q <= PADDED'(features);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
            acc    <= '1;
        end else if (accept) begin
            rd_cnt <= '0;
            acc    <= '1;
        end else if (state == RUN) begin
            if (!last_ev) rd_cnt <= rd_cnt + CW'(1);
            if (ev_en)    acc    <= acc & chunk_pass;
        end
    end

`ifdef TM_EMPTY_CLAUSE_ZERO_EN
    logic [N_CLAUSES-1:0] incl;
    logic [N_CLAUSES-1:0] chunk_incl;

    always_comb begin
        logic [2*CHUNK-1:0] lane_i;
        lane_i     = '0;
        chunk_incl = '0;
        for (int c = 0; c < N_CLAUSES; c++) begin
            lane_i        = ta_rdata[c*2*CHUNK +: 2*CHUNK];
            chunk_incl[c] = |(~lane_i & ~{pad, pad});
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept)        incl <= '0;
        else if (ev_en)           incl <= incl | chunk_incl;
    end

    assign clause_eff = acc & incl;
`else
    assign clause_eff = acc;
`endif

    // Even clauses vote positive, odd clauses negative.
    always_comb begin
        sum_acc = '0;
        for (int c = 0; c < N_CLAUSES; c++) begin
            if (clause_eff[c]) begin
                if (c % 2 == 0) sum_acc = sum_acc + SUM_W'(1);
                else            sum_acc = sum_acc - SUM_W'(1);
            end
        end
    end

    assign clause_out = (state == DONE) ? clause_eff : '0;
    assign class_sum  = (state == DONE) ? sum_acc : '0;

endmodule

// File: tb/tb_tm_clause_engine.sv
// Self-checking bench for tm_clause_engine: TA memory model, reference clause model
// and a scoreboard queue of expected results popped when out_valid is seen.
module tb_tm_clause_engine;

    localparam int NF  = 784;
    localparam int CH  = 32;
    localparam int NC  = 16;
    localparam int NCH = (NF + CH - 1) / CH;
    localparam int AW  = 5;
    localparam int SW  = 5;
    localparam int LW  = NC * 2 * CH;

    typedef struct packed {
        logic [NC-1:0]        clauses;
        logic signed [SW-1:0] sum;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [NF-1:0]        features;
    logic                 ta_rd_en;
    logic [AW-1:0]        ta_addr;
    logic [LW-1:0]        ta_rdata = '0;
    logic                 out_valid;
    logic                 out_ready;
    logic [NC-1:0]        clause_out;
    logic signed [SW-1:0] class_sum;

    logic [LW-1:0] mem [NCH];
    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;

    tm_clause_engine dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .features   (features),
        .ta_rd_en   (ta_rd_en),
        .ta_addr    (ta_addr),
        .ta_rdata   (ta_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clause_out (clause_out),
        .class_sum  (class_sum)
    );

    always #5 clk = ~clk;

    // One-cycle read latency TA memory; idle cycles return all-included junk.
    always @(posedge clk) ta_rdata <= ta_rd_en ? mem[ta_addr] : '0;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [NF-1:0] f);
        exp_t e;
        logic fire;
`ifdef TM_EMPTY_CLAUSE_ZERO_EN
        logic any;
`endif
        e.clauses = '0;
        e.sum     = '0;
        for (int c = 0; c < NC; c++) begin
            fire = 1'b1;
`ifdef TM_EMPTY_CLAUSE_ZERO_EN
            any  = 1'b0;
`endif
            for (int i = 0; i < NF; i++) begin
                if (!mem[i/CH][c*2*CH + CH + i%CH]) begin
                    if (!f[i]) fire = 1'b0;
`ifdef TM_EMPTY_CLAUSE_ZERO_EN
                    any = 1'b1;
`endif
                end
                if (!mem[i/CH][c*2*CH + i%CH]) begin
                    if (f[i]) fire = 1'b0;
`ifdef TM_EMPTY_CLAUSE_ZERO_EN
                    any = 1'b1;
`endif
                end
            end
`ifdef TM_EMPTY_CLAUSE_ZERO_EN
            if (!any) fire = 1'b0;
`endif
            e.clauses[c] = fire;
            if (fire) begin
                if (c % 2 == 0) e.sum = e.sum + 5'sd1;
                else            e.sum = e.sum - 5'sd1;
            end
        end
        return e;
    endfunction

    function automatic logic [NF-1:0] rand_feat();
        logic [NCH*CH-1:0] w;
        for (int k = 0; k < NCH; k++) w[k*CH +: CH] = $urandom;
        return w[NF-1:0];
    endfunction

    task automatic masks_all_ones();
        for (int k = 0; k < NCH; k++) mem[k] = '1;
    endtask

    task automatic masks_sparse(input int n_incl);
        masks_all_ones();
        for (int n = 0; n < n_incl; n++)
            mem[$urandom_range(0, NCH-1)][$urandom_range(0, LW-1)] = 1'b0;
    endtask

    task automatic run_sample(input logic [NF-1:0] f, input int hold, input string tag);
        exp_t e;
        int   edges;
        sb.push_back(model(f));
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        features  = f;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        edges = 0;
        while (edges < 200) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            edges++;
        end
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".latency"}, 64'(edges + 1), 64'(NCH + 2));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".clause_out"}, 64'(clause_out), 64'(e.clauses));
            check({tag, ".class_sum"}, 64'(class_sum), 64'(e.sum));
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                check({tag, ".hold_clause"}, 64'(clause_out), 64'(e.clauses));
                check({tag, ".hold_sum"}, 64'(class_sum), 64'(e.sum));
                check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
                check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
                check({tag, ".hold_rd_en"}, 64'(ta_rd_en), 64'd0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".idle_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, ".idle_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [NF-1:0] f;
        int            seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; features = '0;
        masks_all_ones();
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.ta_rd_en", 64'(ta_rd_en), 64'd0);
        check("rst.ta_addr", 64'(ta_addr), 64'd0);
        check("rst.clause_out", 64'(clause_out), 64'd0);
        check("rst.class_sum", 64'(class_sum), 64'd0);
        @(negedge clk) rst = 1'b0;

        masks_all_ones();
        run_sample(rand_feat(), 0, "all_excl");

        mem[0][32] = 1'b0;
        f = rand_feat(); f[0] = 1'b1;
        run_sample(f, 0, "pos_f0_hi");
        f[0] = 1'b0;
        run_sample(f, 0, "pos_f0_lo");

        masks_all_ones();
        for (int c = 0; c < 3; c++) mem[NCH-1][c*2*CH + 15] = 1'b0;
        f = rand_feat(); f[783] = 1'b0;
        run_sample(f, 0, "neg_f783_lo");
        f[783] = 1'b1;
        run_sample(f, 0, "neg_f783_hi");

        masks_all_ones();
        mem[NCH-1] = '0;
        run_sample('1, 0, "last_chunk_ones");
        run_sample('0, 0, "last_chunk_zeros");

        masks_all_ones();
        for (int c = 0; c < NC; c++)
            for (int j = 16; j < CH; j++) begin
                mem[NCH-1][c*2*CH + j]      = 1'b0;
                mem[NCH-1][c*2*CH + CH + j] = 1'b0;
            end
        run_sample(rand_feat(), 0, "pad_only");

        masks_sparse(6);
        run_sample(rand_feat(), 10, "backpressure");

        masks_sparse(8);
        @(negedge clk);
        features = rand_feat(); in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("midrst.ta_rd_en_k10", 64'(ta_rd_en), 64'd1);
        check("midrst.ta_addr_k10", 64'(ta_addr), 64'd10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.ta_rd_en", 64'(ta_rd_en), 64'd0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst.no_partial", 64'(seen), 64'd0);
        run_sample(rand_feat(), 0, "after_rst");

        for (int n = 0; n < 3; n++) begin
            masks_sparse(4);
            f = rand_feat();
            run_sample(f, 0, "rand_sparse");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tm_clause_engine.md
Name: tm_clause_engine

Overview:
- Multi-clause, chunk-serial Tsetlin Machine clause evaluator for one class.
- Accepts one N_FEATURES-bit Boolean input vector over a valid/ready handshake.
- Streams per-chunk exclude masks for all clauses from an external TA-state memory, ANDs literal matches across chunks, then emits the clause vector and the signed polarity-weighted class sum.
- Sits between the feature booleanizer and the class argmax stage; replaces the single-clause, fully parallel combinational evaluator.

Parameters:
- N_FEATURES, 784: Boolean features per sample.
- CHUNK, 32: features evaluated per cycle.
- N_CLAUSES, 16: clauses per class; must be even.
- NCHUNK (localparam), ceil(N_FEATURES/CHUNK): chunks per sample; 25 at defaults.
- AW (localparam), max(1, $clog2(NCHUNK)): chunk address width.
- SUM_W (localparam), $clog2(N_CLAUSES)+1: class sum width.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: features valid.
- in_ready, output, 1: engine idle, can accept.
- features, input, N_FEATURES: Boolean input vector.
- ta_rd_en, output, 1: TA memory read strobe.
- ta_addr, output, AW: chunk index to read.
- ta_rdata, input, N_CLAUSES*2*CHUNK: exclude masks; valid exactly 1 cycle after ta_rd_en.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts result.
- clause_out, output, N_CLAUSES: per-clause output bits.
- class_sum, output, SUM_W (signed): positive-polarity fires minus negative-polarity fires.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - out_valid=0, clause_out=0, class_sum=0, ta_rd_en=0, ta_addr=0.
  - Clause accumulators are set to all ones.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation aborts the sample with no partial output; late ta_rdata is ignored.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register features (zero-padded to NCHUNK*CHUNK bits), set all accumulators to 1, go to RUN.
- RUN:
  - ta_rd_en=1 with ta_addr=k in RUN cycle k, for k=0..NCHUNK-1.
  - In the cycle after each read, chunk k is evaluated from ta_rdata.
  - Lane layout for clause c: slice [c*2*CHUNK +: 2*CHUNK].
    - Upper CHUNK bits exclude positive literals: feature bit j excluded when mask bit CHUNK+j=1.
    - Lower CHUNK bits exclude negated literals: ~feature bit j excluded when mask bit j=1.
    - 1 = excluded.
  - Update rule: acc[c] &= &(mask | {f_chunk, ~f_chunk}).
  - Padding features (index >= N_FEATURES) are forced to pass for both literals, regardless of mask contents.
  - After evaluating chunk NCHUNK-1, go to DONE.
  - ta_rd_en=0 on the final evaluation cycle.
- DONE:
  - clause_out=acc (after optional-feature masking).
  - class_sum = popcount(even-index clauses) - popcount(odd-index clauses). Even index = positive polarity.
  - out_valid=1.
  - Outputs are held stable until out_valid&out_ready, then the engine returns to IDLE.
  - in_ready=0 in DONE; there is no same-cycle accept.
- Latency:
  - Accept edge at cycle T gives out_valid high from cycle T+NCHUNK+2 (27 at defaults) when out_ready is held high.
  - Throughput is one sample per NCHUNK+3 cycles.
- in_ready is combinational from state only; in_valid is not required to stay high after a non-accepted cycle.
- class_sum range is [-N_CLAUSES/2, +N_CLAUSES/2]; it is sign-extended two's complement and never saturates.

Optional Feature:
- Macro TM_EMPTY_CLAUSE_ZERO_EN.
- Defined:
  - The engine tracks a per-clause "any literal included" flag (OR of ~mask across all valid chunks).
  - A clause with no included literal outputs 0 and does not count in class_sum. This is inference-mode semantics.
- Undefined:
  - An empty clause outputs 1 (plain AND over all-excluded literals) and counts in class_sum.
  - No extra flag registers are built.

Test Plan:
- All masks all ones (every literal excluded), features random:
  - Without macro: clause_out=16'hFFFF, class_sum=0.
  - With macro: clause_out=0, class_sum=0.
- Clause 0 includes only positive literal of feature 0 (chunk 0 mask bit 32 cleared), all else excluded:
  - features[0]=1 gives clause_out[0]=1, class_sum=+1.
  - features[0]=0 gives clause_out[0]=0.
- Clauses 0, 2 and 1 each include negated feature 783; feature 783=0 -> clause_out=16'h0007, class_sum=+1.
- Chunk 24 masks all zero, all other chunks all ones, features all 1 -> padding ignored but the negated literals of features 768..783 fail, so clause_out=0.
  - Same stimulus with features all 0 -> positive literals fail, clause_out=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, no ta_rd_en; out_ready=1 -> IDLE next cycle, in_ready=1.
- rst asserted at RUN cycle k=10 -> next cycle IDLE, out_valid=0, ta_rd_en=0; the following sample evaluates correctly with 27-cycle latency.
